// File: rtl/hdr_weight_accum.sv
// Per-pixel HDR merge front end: accumulates hat-weighted exposures, launches the Q24.8 divider, streams radiance.
// Optional HDR_ZERO_FALLBACK_EN: an all-zero-weight pixel outputs its last sample as Q24.8 instead of 0.
module hdr_weight_accum #(
    parameter int unsigned NUM_EXP = 3,
    parameter int unsigned X_W     = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_valid,
    output logic           pix_ready,
    input  logic [7:0]     pix_z,
    input  logic [X_W-1:0] pix_x,
    output logic [31:0]    div_a,
    output logic [31:0]    div_b,
    output logic           div_valid,
    input  logic [31:0]    div_q,
    input  logic           div_ready,
    input  logic           div_ovf,
    output logic           hdr_valid,
    input  logic           hdr_ready,
    output logic [31:0]    hdr_data,
    output logic           hdr_zero
);
    localparam int unsigned W_W   = 7;
    localparam int unsigned P_W   = X_W + W_W;
    localparam int unsigned S_W   = ((P_W > 32) ? P_W : 32) + 1;
    localparam int unsigned CNT_W = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
    localparam int unsigned DEN_W = 16;

    typedef enum logic [1:0] {ACCUM, DIV_START, DIV_WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      num, num_nxt;
    logic [DEN_W-1:0] den, den_nxt;
    logic [31:0]      div_a_nxt, div_b_nxt, hdr_data_nxt;
    logic             hdr_zero_nxt;

    logic [W_W-1:0]   weight;
    logic [P_W-1:0]   prod;
    logic [S_W-1:0]   num_sum;
    logic [31:0]      num_acc;
    logic [DEN_W-1:0] den_acc;
    logic             xfer, first, last;

    // Hat weight and accumulate; the first sample of a pixel loads instead of adding.
    always_comb begin
        weight  = pix_z[7] ? W_W'(8'd255 - pix_z) : W_W'(pix_z);
        prod    = P_W'(weight) * P_W'(pix_x);
        xfer    = pix_valid && (state == ACCUM);
        first   = (cnt == '0);
        last    = (cnt == CNT_W'(NUM_EXP - 1));
        num_sum = (first ? S_W'(0) : S_W'(num)) + S_W'(prod);
        num_acc = (|num_sum[S_W-1:32]) ? '1 : num_sum[31:0];
        den_acc = (first ? DEN_W'(0) : den) + DEN_W'(weight);
    end

    // Next-state and registered-output values.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        num_nxt      = num;
        den_nxt      = den;
        div_a_nxt    = div_a;
        div_b_nxt    = div_b;
        hdr_data_nxt = hdr_data;
        hdr_zero_nxt = hdr_zero;
        unique case (state)
            ACCUM: begin
                if (xfer) begin
                    num_nxt = num_acc;
                    den_nxt = den_acc;
                    cnt_nxt = last ? '0 : cnt + CNT_W'(1);
                    if (last) begin
                        if (den_acc != '0) begin
                            state_nxt = DIV_START;
                            div_a_nxt = num_acc;
                            div_b_nxt = 32'(den_acc);
                        end else begin
                            state_nxt    = DONE;
                            hdr_zero_nxt = 1'b1;
`ifdef HDR_ZERO_FALLBACK_EN
                            hdr_data_nxt = 32'({pix_x, 8'h00});
`else
                            hdr_data_nxt = '0;
`endif
                        end
                    end
                end
            end
            DIV_START: state_nxt = DIV_WAIT;
            DIV_WAIT: begin
                if (div_ready) begin
                    state_nxt    = DONE;
                    hdr_zero_nxt = 1'b0;
                    hdr_data_nxt = div_ovf ? '1 : div_q;
                end
            end
            DONE: begin
                if (hdr_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // State and output registers; handshake flags decode the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            cnt       <= '0;
            num       <= '0;
            den       <= '0;
            div_a     <= '0;
            div_b     <= '0;
            hdr_data  <= '0;
            hdr_zero  <= 1'b0;
            pix_ready <= 1'b1;
            div_valid <= 1'b0;
            hdr_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            num       <= num_nxt;
            den       <= den_nxt;
            div_a     <= div_a_nxt;
            div_b     <= div_b_nxt;
            hdr_data  <= hdr_data_nxt;
            hdr_zero  <= hdr_zero_nxt;
            pix_ready <= (state_nxt == ACCUM);
            div_valid <= (state_nxt == DIV_START);
            hdr_valid <= (state_nxt == DONE);
        end
    end
endmodule

// File: tb/tb_hdr_weight_accum.sv
// Randomized self-checking bench for hdr_weight_accum against an arithmetic per-pixel reference model.
// Honours HDR_ZERO_FALLBACK_EN for the zero-weight expectation.
module tb_hdr_weight_accum;
    localparam int unsigned NUM_EXP = 3;
    localparam int unsigned X_W     = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           pix_valid, pix_ready;
    logic [7:0]     pix_z;
    logic [X_W-1:0] pix_x;
    logic [31:0]    div_a, div_b, div_q, hdr_data;
    logic           div_valid, div_ready, div_ovf;
    logic           hdr_valid, hdr_ready, hdr_zero;

    logic           w_pix_valid, w_pix_ready;
    logic [7:0]     w_pix_z;
    logic [23:0]    w_pix_x;
    logic [31:0]    w_div_a, w_div_b, w_div_q, w_hdr_data;
    logic           w_div_valid, w_div_ready, w_div_ovf;
    logic           w_hdr_valid, w_hdr_ready, w_hdr_zero;

    int n_checks = 0;
    int n_errors = 0;

    hdr_weight_accum #(.NUM_EXP(NUM_EXP), .X_W(X_W)) u_dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_z(pix_z), .pix_x(pix_x), .div_a(div_a), .div_b(div_b),
        .div_valid(div_valid), .div_q(div_q), .div_ready(div_ready), .div_ovf(div_ovf),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_data(hdr_data), .hdr_zero(hdr_zero)
    );

    hdr_weight_accum #(.NUM_EXP(3), .X_W(24)) u_dut_w24 (
        .clk(clk), .rst(rst), .pix_valid(w_pix_valid), .pix_ready(w_pix_ready),
        .pix_z(w_pix_z), .pix_x(w_pix_x), .div_a(w_div_a), .div_b(w_div_b),
        .div_valid(w_div_valid), .div_q(w_div_q), .div_ready(w_div_ready), .div_ovf(w_div_ovf),
        .hdr_valid(w_hdr_valid), .hdr_ready(w_hdr_ready), .hdr_data(w_hdr_data), .hdr_zero(w_hdr_zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint unsigned hat(input int unsigned z);
        return (z < 128) ? longint'(z) : longint'(255 - z);
    endfunction

    task automatic chk_reset_state();
        chk("rst_pix_ready", 32'(pix_ready), 32'd1);
        chk("rst_div_valid", 32'(div_valid), 32'd0);
        chk("rst_div_a", div_a, 32'd0);
        chk("rst_div_b", div_b, 32'd0);
        chk("rst_hdr_valid", 32'(hdr_valid), 32'd0);
        chk("rst_hdr_data", hdr_data, 32'd0);
        chk("rst_hdr_zero", 32'(hdr_zero), 32'd0);
    endtask

    task automatic send(input int unsigned z, input int unsigned x);
        int n = 0;
        pix_z     = 8'(z);
        pix_x     = X_W'(x);
        pix_valid = 1'b1;
        while (!pix_ready && n < 20) begin
            step();
            n++;
        end
        chk("pix_ready_wait", 32'(pix_ready), 32'd1);
        step();
        pix_valid = 1'b0;
    endtask

    // One full pixel: model, stimulus, divider response, output hold and accept.
    task automatic run_pixel(input int unsigned zs[NUM_EXP], input int unsigned xs[NUM_EXP],
                             input bit force_ovf, input int stall);
        longint unsigned num = 0, den = 0, q = 0;
        logic [31:0] exp_data;
        logic        exp_zero;
        bit          ovf;
        for (int i = 0; i < NUM_EXP; i++) begin
            num += hat(zs[i]) * longint'(xs[i]);
            den += hat(zs[i]);
        end
        if (num > 64'hFFFF_FFFF) num = 64'hFFFF_FFFF;
        for (int i = 0; i < NUM_EXP; i++) begin
            repeat ($urandom_range(0, 2)) step();
            send(zs[i], xs[i]);
        end
        if (den == 0) begin
            chk("zero_latency", 32'(hdr_valid), 32'd1);
            chk("zero_no_div", 32'(div_valid), 32'd0);
`ifdef HDR_ZERO_FALLBACK_EN
            exp_data = 32'(xs[NUM_EXP-1]) << 8;
`else
            exp_data = 32'd0;
`endif
            exp_zero = 1'b1;
        end else begin
            chk("div_valid_start", 32'(div_valid), 32'd1);
            chk("div_a", div_a, 32'(num));
            chk("div_b", div_b, 32'(den));
            step();
            chk("div_valid_pulse", 32'(div_valid), 32'd0);
            repeat ($urandom_range(0, 3)) begin
                step();
                chk("wait_hdr_valid", 32'(hdr_valid), 32'd0);
            end
            chk("div_a_stable", div_a, 32'(num));
            chk("div_b_stable", div_b, 32'(den));
            q   = (num << 8) / den;
            ovf = force_ovf || (q > 64'hFFFF_FFFF);
            div_q     = force_ovf ? 32'h1234_5678 : 32'(q);
            div_ovf   = ovf;
            div_ready = 1'b1;
            step();
            div_ready = 1'b0;
            div_ovf   = 1'b0;
            chk("div_hdr_valid", 32'(hdr_valid), 32'd1);
            exp_data = ovf ? 32'hFFFF_FFFF : 32'(q);
            exp_zero = 1'b0;
        end
        chk("hdr_data", hdr_data, exp_data);
        chk("hdr_zero", 32'(hdr_zero), 32'(exp_zero));
        chk("done_pix_ready", 32'(pix_ready), 32'd0);
        repeat (stall) begin
            step();
            chk("stall_hdr_valid", 32'(hdr_valid), 32'd1);
            chk("stall_hdr_data", hdr_data, exp_data);
            chk("stall_pix_ready", 32'(pix_ready), 32'd0);
        end
        hdr_ready = 1'b1;
        step();
        hdr_ready = 1'b0;
        chk("accept_hdr_valid", 32'(hdr_valid), 32'd0);
        chk("accept_pix_ready", 32'(pix_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned zs[NUM_EXP];
        int unsigned xs[NUM_EXP];
        longint unsigned wq;

        rst = 1'b1; pix_valid = 1'b0; pix_z = '0; pix_x = '0;
        div_q = '0; div_ready = 1'b0; div_ovf = 1'b0; hdr_ready = 1'b0;
        w_pix_valid = 1'b0; w_pix_z = '0; w_pix_x = '0;
        w_div_q = '0; w_div_ready = 1'b0; w_div_ovf = 1'b0; w_hdr_ready = 1'b0;
        repeat (2) step();
        chk_reset_state();
        rst = 1'b0;
        step();

        zs = '{128, 64, 200}; xs = '{100, 200, 50};
        run_pixel(zs, xs, 1'b0, 5);
        chk("spec_example_q", hdr_data, 32'd29398);

        zs = '{0, 255, 0}; xs = '{7, 8, 9};
        run_pixel(zs, xs, 1'b0, 2);

        zs = '{10, 20, 30}; xs = '{1000, 2000, 3000};
        run_pixel(zs, xs, 1'b1, 1);

        // Stray divider strobe while accumulating must be ignored.
        div_q = 32'hDEAD_BEEF; div_ready = 1'b1;
        step();
        div_ready = 1'b0;
        chk("stray_hdr_valid", 32'(hdr_valid), 32'd0);
        chk("stray_pix_ready", 32'(pix_ready), 32'd1);

        // Reset mid-divide, then a late divider strobe.
        send(127, 500); send(127, 600); send(127, 700);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_state();
        div_q = 32'h0000_1111; div_ready = 1'b1;
        step();
        div_ready = 1'b0;
        chk("late_ready_hdr_valid", 32'(hdr_valid), 32'd0);
        step();
        chk("late_ready_hdr_valid2", 32'(hdr_valid), 32'd0);
        zs = '{50, 150, 250}; xs = '{400, 300, 200};
        run_pixel(zs, xs, 1'b0, 0);

        // Partial pixel discarded by reset.
        send(90, 1234); send(91, 4321);
        rst = 1'b1;
        step();
        rst = 1'b0;
        zs = '{1, 2, 3}; xs = '{65535, 65535, 65535};
        run_pixel(zs, xs, 1'b0, 0);

        for (int p = 0; p < 40; p++) begin
            for (int i = 0; i < NUM_EXP; i++) begin
                if (p % 7 == 3 || $urandom_range(0, 7) == 0)
                    zs[i] = ($urandom_range(0, 1) != 0) ? 255 : 0;
                else
                    zs[i] = $urandom_range(0, 255);
                xs[i] = $urandom_range(0, 65535);
            end
            run_pixel(zs, xs, ($urandom_range(0, 9) == 0), int'($urandom_range(0, 5)));
        end

        // Wide-sample instance: numerator saturation.
        for (int i = 0; i < 3; i++) begin
            w_pix_z = 8'd127; w_pix_x = 24'hFF_FFFF; w_pix_valid = 1'b1;
            chk("w24_pix_ready", 32'(w_pix_ready), 32'd1);
            step();
        end
        w_pix_valid = 1'b0;
        chk("w24_div_valid", 32'(w_div_valid), 32'd1);
        chk("w24_div_a_sat", w_div_a, 32'hFFFF_FFFF);
        chk("w24_div_b", w_div_b, 32'd381);
        step(); step();
        wq = (64'hFFFF_FFFF << 8) / 381;
        w_div_q = 32'(wq); w_div_ready = 1'b1;
        step();
        w_div_ready = 1'b0;
        chk("w24_hdr_valid", 32'(w_hdr_valid), 32'd1);
        chk("w24_hdr_data", w_hdr_data, 32'(wq));
        chk("w24_hdr_zero", 32'(w_hdr_zero), 32'd0);
        w_hdr_ready = 1'b1;
        step();
        w_hdr_ready = 1'b0;
        chk("w24_accept_pix_ready", 32'(w_pix_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
